// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, stop-bit encodings and the stop-phase tick target.
package uart_pkg;
  localparam int OVRSAMPLING_DEF = 16;
  localparam logic [1:0] STOP_1 = 2'b00;
  localparam logic [1:0] STOP_1P5 = 2'b01;
  localparam logic [1:0] STOP_2 = 2'b10;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  // 2'b11 falls through to the 2-stop length
  function automatic logic [5:0] stop_ticks(input logic [1:0] sb);
    return sb == STOP_1 ? 6'd16 : sb == STOP_1P5 ? 6'd24 : 6'd32;
  endfunction
endpackage

// File: rtl/uart_tx_engine_if.sv
// uart_tx_engine_if: frame request, format fields and serial outputs of the TX engine.
interface uart_tx_engine_if;
  logic s_tick;
  logic tx_start;
  logic [7:0] din;
  logic data_bit;
  logic parity_en;
  logic parity_pol;
  logic [1:0] stop_bits;
  logic tx_busy;
  logic tx_done_tick;
  logic tx;
  modport master (output s_tick, tx_start, din, data_bit, parity_en, parity_pol, stop_bits,
                  input tx_busy, tx_done_tick, tx);
  modport slave (input s_tick, tx_start, din, data_bit, parity_en, parity_pol, stop_bits,
                 output tx_busy, tx_done_tick, tx);
endinterface

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: serializes one byte per frame (start, 7/8 data LSB-first, optional parity, 1/1.5/2 stop).
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int OVRSAMPLING = OVRSAMPLING_DEF,
  parameter int DATA_BITS = 8
) (
  input logic clk,
  input logic reset,
  uart_tx_engine_if.slave bus
);
  localparam logic [4:0] S_LAST = 5'(OVRSAMPLING - 1);
  localparam logic [2:0] LAST8 = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST7 = 3'(DATA_BITS - 2);
  tx_state_t state_q, state_d;
  logic [4:0] s_cnt_q, s_cnt_d;
  logic [2:0] n_cnt_q, n_cnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic b7_q, b7_d, pe_q, pe_d, par_q, par_d;
  logic [1:0] sb_q, sb_d;
  logic tx_q, tx_d, done_q, done_d;
  logic bit_end, stop_end;
  assign bit_end = bus.s_tick && s_cnt_q == S_LAST;
  assign stop_end = bus.s_tick && {1'b0, s_cnt_q} == stop_ticks(sb_q) - 6'd1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      sh_q <= '0;
      b7_q <= 1'b0;
      pe_q <= 1'b0;
      par_q <= 1'b0;
      sb_q <= '0;
      tx_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      sh_q <= sh_d;
      b7_q <= b7_d;
      pe_q <= pe_d;
      par_q <= par_d;
      sb_q <= sb_d;
      tx_q <= tx_d;
      done_q <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    s_cnt_d = (state_q != IDLE && bus.s_tick) ? s_cnt_q + 5'd1 : s_cnt_q;
    n_cnt_d = n_cnt_q;
    sh_d = sh_q;
    b7_d = b7_q;
    pe_d = pe_q;
    par_d = par_q;
    sb_d = sb_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.tx_start) begin
        state_d = START;
        s_cnt_d = '0;
        n_cnt_d = '0;
        sh_d = bus.din;
        b7_d = bus.data_bit;
        pe_d = bus.parity_en;
        // parity fixed at acceptance since the shifter consumes the data
        par_d = ^(bus.din & (bus.data_bit ? 8'h7F : 8'hFF)) ^ ~bus.parity_pol;
        sb_d = bus.stop_bits;
      end
      START: if (bit_end) begin
        s_cnt_d = '0;
        state_d = DATA;
      end
      DATA: if (bit_end) begin
        s_cnt_d = '0;
        sh_d = sh_q >> 1;
        n_cnt_d = n_cnt_q + 3'd1;
        if (n_cnt_q == (b7_q ? LAST7 : LAST8)) state_d = pe_q ? PARITY : STOP;
      end
      PARITY: if (bit_end) begin
        s_cnt_d = '0;
        state_d = STOP;
      end
      STOP: if (stop_end) begin
        s_cnt_d = '0;
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    tx_d = state_q == START ? 1'b0 : state_q == DATA ? sh_q[0] : state_q == PARITY ? par_q : 1'b1;
  end
  assign bus.tx = tx_q;
  assign bus.tx_busy = state_q != IDLE;
  assign bus.tx_done_tick = done_q;
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: randomized frames checked tick-by-tick against a bit-list reference model.
module tb_uart_tx_engine;
  typedef struct {
    logic [7:0] din;
    bit db, pe, pp;
    logic [1:0] sb;
    int per;
    bit chain;
    int abort;
  } frame_t;
  localparam int NF = 17;
  logic clk, reset;
  int n_chk, n_err;
  frame_t fr[NF];
  uart_tx_engine_if bus();
  uart_tx_engine dut (.clk(clk), .reset(reset), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input frame_t f);
    bus.din = f.din;
    bus.data_bit = f.db;
    bus.parity_en = f.pe;
    bus.parity_pol = f.pp;
    bus.stop_bits = f.sb;
    bus.tx_start = 1'b1;
  endtask
  task automatic run_frame(input frame_t f, input bit pre, input frame_t nxt);
    bit lvl[10];
    int n, p, tot, c, c_lag, mid, ones;
    bit t, aborted;
    n = f.db ? 7 : 8;
    p = f.pe ? 1 : 0;
    tot = 16 * (1 + n + p) + (f.sb == 2'b00 ? 16 : f.sb == 2'b01 ? 24 : 32);
    lvl[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      lvl[1 + i] = f.din[i];
      ones += f.din[i] ? 1 : 0;
    end
    lvl[1 + n] = ((ones % 2) == 1) == f.pp;
    if (!pre) begin
      @(negedge clk);
      drive(f);
    end
    @(negedge clk);
    check("accept_tx_high", bus.tx, 1);
    check("accept_no_done", bus.tx_done_tick, 0);
    bus.tx_start = 1'b0;
    c = 0;
    aborted = 1'b0;
    mid = 5 + $urandom_range(0, 60);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      t = f.per == 0 ? 1'($urandom_range(0, 1)) : (cyc % f.per == 0);
      bus.s_tick = t;
      if (cyc == mid) begin
        bus.tx_start = 1'b1;
        bus.din = 8'hAA;
        bus.data_bit = 1'($urandom);
        bus.parity_en = 1'($urandom);
        bus.parity_pol = 1'($urandom);
        bus.stop_bits = 2'($urandom);
      end
      if (cyc == mid + 1) bus.tx_start = 1'b0;
      @(negedge clk);
      c_lag = c;
      c += t ? 1 : 0;
      check("tx", bus.tx, (c_lag / 16) < (1 + n + p) ? lvl[c_lag / 16] : 1'b1);
      check("done", bus.tx_done_tick, c == tot);
      check("busy", bus.tx_busy, c != tot);
      if (f.abort != 0 && c == f.abort) begin
        aborted = 1'b1;
        break;
      end
      if (c == tot) break;
    end
    bus.s_tick = 1'b0;
    bus.tx_start = 1'b0;
    if (aborted) begin
      #3 reset = 1'b1;
      #1;
      check("rst_tx", bus.tx, 1);
      check("rst_busy", bus.tx_busy, 0);
      check("rst_done", bus.tx_done_tick, 0);
      @(negedge clk);
      check("rst_hold_done", bus.tx_done_tick, 0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_done", bus.tx_done_tick, 0);
      check("post_rst_tx", bus.tx, 1);
    end else begin
      check("frame_len", c, tot);
      if (f.chain) drive(nxt);
      else begin
        @(negedge clk);
        check("idle_done_low", bus.tx_done_tick, 0);
        check("idle_tx", bus.tx, 1);
        check("idle_busy", bus.tx_busy, 0);
      end
    end
  endtask
  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    bus.s_tick = 1'b1;
    bus.tx_start = 1'b1;
    bus.din = 8'h00;
    bus.data_bit = 1'b0;
    bus.parity_en = 1'b0;
    bus.parity_pol = 1'b0;
    bus.stop_bits = 2'b00;
    #1;
    check("reset_tx", bus.tx, 1);
    check("reset_busy", bus.tx_busy, 0);
    check("reset_done", bus.tx_done_tick, 0);
    repeat (2) @(negedge clk);
    check("reset_held_busy", bus.tx_busy, 0);
    bus.tx_start = 1'b0;
    bus.s_tick = 1'b0;
    reset = 1'b0;
    fr[0] = '{8'h55, 0, 0, 0, 2'b00, 1, 0, 0};
    fr[1] = '{8'h07, 0, 1, 1, 2'b00, 1, 0, 0};
    fr[2] = '{8'h07, 0, 1, 0, 2'b00, 2, 0, 0};
    fr[3] = '{8'hC1, 1, 1, 0, 2'b10, 1, 0, 0};
    fr[4] = '{8'hFF, 0, 0, 0, 2'b01, 4, 0, 0};
    fr[5] = '{8'h3C, 0, 1, 1, 2'b11, 3, 1, 0};
    fr[6] = '{8'h96, 1, 0, 0, 2'b01, 0, 0, 0};
    fr[7] = '{8'hA5, 0, 1, 1, 2'b00, 1, 0, 40};
    fr[8] = '{8'h5A, 0, 1, 0, 2'b10, 2, 0, 0};
    for (int i = 9; i < NF; i++) begin
      fr[i].din = 8'($urandom);
      fr[i].db = 1'($urandom);
      fr[i].pe = 1'($urandom);
      fr[i].pp = 1'($urandom);
      fr[i].sb = 2'($urandom);
      fr[i].per = $urandom_range(0, 3);
      fr[i].chain = (i < NF - 1) ? 1'($urandom) : 1'b0;
      fr[i].abort = 0;
    end
    for (int i = 0; i < NF; i++)
      run_frame(fr[i], i > 0 && fr[i - 1].chain, fr[(i + 1) % NF]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
